spi_reg_master: RTL and testbench

- SPI initiator (mode 0) that drives the 4-wire register-access port of the peripheral test harness.
- Lets a testbench or on-chip sequencer issue single-byte register writes and reads through a simple start/done handshake.
- One transaction per start: a 16-bit frame carrying R/W flag, address and data.

---
 rtl/spi_reg_master.sv | 154 +++++++++++++++
 tb/tb_spi_reg_master.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/spi_reg_master.sv
// rtl/spi_reg_master.sv - SPI mode-0 register-access initiator with start/done handshake
module spi_reg_master #(
  parameter int ADDR_W  = 4,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic              busy,
  output logic              done,
  output logic [7:0]        rdata,
  output logic              spi_cs_n,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  // Hold is stretched so that, with a CLK_DIV-cycle cs_n gap (done cycle included),
  // the start-to-done latency is 36*CLK_DIV+1 cycles.
  localparam int HOLD_CYC = 2 * CLK_DIV + 2;
  localparam int CNT_W    = $clog2(HOLD_CYC);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CLK_DIV - 2);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       half_q, half_d;
  logic [15:0]      shreg_q, shreg_d;
  logic [7:0]       rx_q, rx_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             wr_q, wr_d;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    half_d  = half_q;
    shreg_d = shreg_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          shreg_d = {write, 7'(addr), (write ? wdata : 8'h00)};
          wr_d    = write;
          mosi_d  = write;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          half_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d  = '0;
          half_d = half_q + 5'd1;
          if (!half_q[0]) begin
            sclk_d = 1'b1;
          end else begin
            // End of a high half: sample MISO, then present the next bit for the low half.
            rx_d   = {rx_q[6:0], spi_miso};
            sclk_d = 1'b0;
            if (half_q == 5'd31) begin
              state_d = HOLD;
            end else begin
              mosi_d  = shreg_q[14];
              shreg_d = {shreg_q[14:0], 1'b0};
            end
          end
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
          if (!wr_q) rdata_d = rx_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      half_q  <= '0;
      shreg_q <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      shreg_q <= shreg_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign spi_cs_n = cs_n_q;
  assign spi_clk  = sclk_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_reg_master.sv
// tb/tb_spi_reg_master.sv - directed and random register transactions against a register-file SPI slave
module tb_spi_reg_master;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       write;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       spi_cs_n;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_miso = 1'b0;

  spi_reg_master #(.ADDR_W(4), .CLK_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .write(write), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  // Register-file slave: 7-bit address space, returns the addressed byte in the data phase.
  logic [7:0]  smem [128] = '{default: 8'h00};
  logic [15:0] s_frame = '0, last_frame = '0;
  logic [6:0]  s_addr = '0;
  int          s_rises = 0, s_falls = 0, last_rises = 0, total_rises = 0, hi_cnt = 0, last_gap = 0;
  logic        prev_sclk = 1'b0, prev_cs = 1'b1;

  always @(negedge clk) begin
    if (spi_clk === 1'b1 && !prev_sclk) total_rises++;
    if (spi_cs_n !== 1'b0) begin
      if (!prev_cs) begin
        last_frame = s_frame;
        last_rises = s_rises;
        if (s_rises == 16 && s_frame[15]) smem[s_frame[14:8]] = s_frame[7:0];
      end
      s_rises = 0;
      s_falls = 0;
      hi_cnt++;
    end else begin
      if (prev_cs) begin
        last_gap = hi_cnt;
        hi_cnt   = 0;
      end
      if (spi_clk && !prev_sclk) begin
        s_frame = {s_frame[14:0], spi_mosi};
        s_rises++;
        if (s_rises == 8) s_addr = s_frame[6:0];
      end
      if (!spi_clk && prev_sclk) s_falls++;
    end
    spi_miso  = (spi_cs_n === 1'b0 && s_falls >= 8 && s_falls < 16) ? smem[s_addr][3'(15 - s_falls)] : 1'b0;
    prev_sclk = (spi_clk === 1'b1);
    prev_cs   = (spi_cs_n !== 1'b0);
  end

  int         total = 0, bad = 0;
  logic [7:0] ref_mem [16] = '{default: 8'h00};
  logic [7:0] exp_rdata = 8'h00;
  logic       nxt_w;
  logic [3:0] nxt_a;
  logic [7:0] nxt_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic w, input logic [3:0] a, input logic [7:0] d,
                     input bit chained, input bit poke, input bit b2b);
    int n;
    logic [15:0] exp_frame;
    exp_frame = {w, 3'b000, a, (w ? d : 8'h00)};
    if (!chained) begin
      @(negedge clk);
      start = 1'b1; write = w; addr = a; wdata = d;
      @(posedge clk);
    end
    n = 0;
    forever begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = 1'b0;
      if (n == 1) chk("busy_rise", busy, 1);
      if (poke && n == 20) begin
        start = 1'b1; write = ~w; addr = ~a; wdata = ~d;
      end
      if (done === 1'b1 || n > 400) break;
    end
    chk("latency", n, 36 * D + 1);
    chk("busy_at_done", busy, 0);
    chk("frame", last_frame, exp_frame);
    chk("rises", last_rises, 16);
    if (w) ref_mem[a] = d;
    else   exp_rdata = ref_mem[a];
    chk("rdata", rdata, exp_rdata);
    if (b2b) begin
      start = 1'b1; write = nxt_w; addr = nxt_a; wdata = nxt_d;
      @(posedge clk);
    end
  endtask

  initial begin
    int n;
    int dcnt;
    rst_n = 1'b0; start = 1'b1; write = 1'b1; addr = 4'hF; wdata = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_cs_n", spi_cs_n, 1);
      chk("rst_sclk", spi_clk, 0);
      chk("rst_mosi", spi_mosi, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rdata", rdata, 0);
    end
    rst_n = 1'b1; start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_no_start", busy, 0);
    chk("rst_no_edges", total_rises, 0);

    txn(1'b1, 4'h5, 8'hA5, 1'b0, 1'b1, 1'b0);
    txn(1'b1, 4'h3, 8'h3C, 1'b0, 1'b0, 1'b0);
    nxt_w = 1'b0; nxt_a = 4'h3; nxt_d = 8'h00;
    txn(1'b0, 4'h3, 8'h00, 1'b0, 1'b0, 1'b1);
    txn(1'b0, 4'h3, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("b2b_gap", last_gap, D);

    @(negedge clk);
    start = 1'b1; write = 1'b1; addr = 4'h9; wdata = 8'h77;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (s_rises < 5 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach", s_rises, 5);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_cs_n", spi_cs_n, 1);
    chk("abort_sclk", spi_clk, 0);
    chk("abort_mosi", spi_mosi, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rdata", rdata, 0);
    exp_rdata = 8'h00;
    dcnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    txn(1'b1, 4'h1, 8'h12, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
          1'b0, 1'b0, 1'b0);
    end
    txn(1'b0, 4'h9, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
